// File: rtl/new_task_stream_arbiter.sv
// Round-robin packet arbiter merging per-accelerator new-task streams into one output stream.
// Optional stall watchdog is built when NEW_TASK_ARB_WATCHDOG_EN is defined.
module new_task_stream_arbiter #(
  parameter int NUM_ACCS  = 16,
  parameter int ACC_BITS  = $clog2(NUM_ACCS),
  parameter int WD_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ACCS-1:0]    in_tvalid,
  output logic [NUM_ACCS-1:0]    in_tready,
  input  logic [NUM_ACCS*64-1:0] in_tdata,
  input  logic [NUM_ACCS-1:0]    in_tlast,
  input  logic [NUM_ACCS*5-1:0]  in_tdest,
  output logic                   outStream_tvalid,
  input  logic                   outStream_tready,
  output logic [63:0]            outStream_tdata,
  output logic                   outStream_tlast,
  output logic [ACC_BITS-1:0]    outStream_tid,
  output logic [4:0]             outStream_tdest,
  output logic                   wd_error
);

  localparam int BEAT_W = 64 + 1 + 5 + ACC_BITS;
  localparam logic [ACC_BITS-1:0] LAST_ACC = ACC_BITS'(NUM_ACCS - 1);

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ACC_BITS-1:0] grant;
  logic [ACC_BITS-1:0] grant_next;
  logic [ACC_BITS-1:0] rr_ptr;
  logic [ACC_BITS-1:0] rr_ptr_next;

  logic                scan_found;
  logic [ACC_BITS-1:0] scan_pick;
  logic [ACC_BITS-1:0] scan_idx;
  int                  scan_sum;

  logic [1:0]          count;
  logic [BEAT_W-1:0]   head_beat;
  logic [BEAT_W-1:0]   tail_beat;
  logic [BEAT_W-1:0]   in_beat;
  logic                pop;
  logic                full;
  logic                beat_ok;
  logic [63:0]         sel_data;
  logic                sel_last;
  logic [4:0]          sel_dest;

  // Round-robin scan starting at rr_ptr, wrapping past the last accelerator.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = '0;
    scan_idx   = '0;
    scan_sum   = 0;
    for (int k = 0; k < NUM_ACCS; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= NUM_ACCS) begin
        scan_sum = scan_sum - NUM_ACCS;
      end
      scan_idx = ACC_BITS'(scan_sum);
      if (!scan_found && in_tvalid[scan_idx]) begin
        scan_found = 1'b1;
        scan_pick  = scan_idx;
      end
    end
  end

  assign sel_data = in_tdata[64*grant +: 64];
  assign sel_last = in_tlast[grant];
  assign sel_dest = in_tdest[5*grant +: 5];
  assign in_beat  = {sel_data, sel_last, sel_dest, grant};

  assign pop     = (count != 2'd0) && outStream_tready;
  assign full    = (count == 2'd2) && !pop;
  assign beat_ok = (state == XFER) && in_tvalid[grant] && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Grant is held from the first beat until tlast is accepted; a source going idle never loses it.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    in_tready   = '0;
    case (state)
      ARB: begin
        if (scan_found) begin
          grant_next = scan_pick;
          state_next = XFER;
        end
      end
      XFER: begin
        in_tready[grant] = !full;
        if (beat_ok && sel_last) begin
          rr_ptr_next = (grant == LAST_ACC) ? '0 : grant + 1'b1;
          state_next  = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (beat_ok) count <= 2'd1;
        end
        2'd1: begin
          if (beat_ok && !pop) count <= 2'd2;
          else if (!beat_ok && pop) count <= 2'd0;
        end
        default: begin
          if (pop && !beat_ok) count <= 2'd1;
        end
      endcase
    end
  end

  // Payload registers carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    case (count)
      2'd0: begin
        if (beat_ok) head_beat <= in_beat;
      end
      2'd1: begin
        if (beat_ok && pop) head_beat <= in_beat;
        else if (beat_ok) tail_beat <= in_beat;
      end
      default: begin
        if (pop) begin
          head_beat <= tail_beat;
          if (beat_ok) tail_beat <= in_beat;
        end
      end
    endcase
  end

  assign outStream_tvalid = (count != 2'd0);
  assign {outStream_tdata, outStream_tlast, outStream_tdest, outStream_tid} = head_beat;

`ifdef NEW_TASK_ARB_WATCHDOG_EN
  localparam int WD_BITS = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(WD_CYCLES - 1);

  logic [WD_BITS-1:0] wd_count;
  logic               wd_flag;

  // Counts cycles the granted source sits idle; a source blocked by a full buffer is not stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_count <= '0;
      wd_flag  <= 1'b0;
    end else begin
      if (state != XFER || beat_ok) begin
        wd_count <= '0;
      end else if (!in_tvalid[grant] && wd_count != WD_LIMIT) begin
        wd_count <= wd_count + 1'b1;
      end
      if (state == XFER && wd_count == WD_LIMIT) begin
        wd_flag <= 1'b1;
      end
    end
  end

  assign wd_error = wd_flag;
`else
  assign wd_error = 1'b0;
`endif

endmodule

// File: tb/tb_new_task_stream_arbiter.sv
// Scoreboard bench for new_task_stream_arbiter: per-acc source models, expected beats queued at load.
// Expects wd_error=1 after the long stall only when NEW_TASK_ARB_WATCHDOG_EN is defined.
module tb_new_task_stream_arbiter;

  localparam int NA = 16;
  localparam int AB = 4;
  localparam int WD = 16;
`ifdef NEW_TASK_ARB_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [NA-1:0]  in_tvalid;
  logic [NA-1:0]  in_tready;
  logic [NA*64-1:0] in_tdata;
  logic [NA-1:0]  in_tlast;
  logic [NA*5-1:0] in_tdest;
  logic           outStream_tvalid;
  logic           outStream_tready;
  logic [63:0]    outStream_tdata;
  logic           outStream_tlast;
  logic [AB-1:0]  outStream_tid;
  logic [4:0]     outStream_tdest;
  logic           wd_error;

  new_task_stream_arbiter #(
    .NUM_ACCS (NA),
    .ACC_BITS (AB),
    .WD_CYCLES(WD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .in_tdata        (in_tdata),
    .in_tlast        (in_tlast),
    .in_tdest        (in_tdest),
    .outStream_tvalid(outStream_tvalid),
    .outStream_tready(outStream_tready),
    .outStream_tdata (outStream_tdata),
    .outStream_tlast (outStream_tlast),
    .outStream_tid   (outStream_tid),
    .outStream_tdest (outStream_tdest),
    .wd_error        (wd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [73:0] sb_q[$];

  logic [63:0] src_data [NA][32];
  logic        src_last [NA][32];
  logic [4:0]  src_dest [NA];
  int          src_cnt  [NA] = '{default: 0};
  int          src_pos  [NA] = '{default: 0};
  int          stall_at [NA] = '{default: -1};
  int          stall_len[NA] = '{default: 0};
  int          stall_seen[NA] = '{default: 0};
  logic [NA-1:0] acc_mask = '0;
  int          ready_mode = 0;
  logic        prev_hold = 1'b0;
  logic [73:0] prev_beat = '0;
  logic        rdy6_seen;

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadPacket(input int acc, input int n, input logic [63:0] base, input logic [4:0] dest);
    int idx;
    src_dest[acc] = dest;
    for (int i = 0; i < n; i++) begin
      idx = (src_cnt[acc] + i) % 32;
      src_data[acc][idx] = base + 64'(i);
      src_last[acc][idx] = (i == n - 1);
      sb_q.push_back({base + 64'(i), (i == n - 1), dest, AB'(acc)});
    end
    src_cnt[acc] = src_cnt[acc] + n;
  endtask

  function automatic logic srcBusy();
    logic b;
    b = 1'b0;
    for (int a = 0; a < NA; a++) if (src_pos[a] < src_cnt[a]) b = 1'b1;
    return b;
  endfunction

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || srcBusy()) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput(tag, 80'(sb_q.size()), 80'd0);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Source models and output monitor: drive on negedge, sample the settled handshake 1 time unit later.
  always @(negedge clk) begin
    logic stalled;
    logic [73:0] cur_beat;
    for (int a = 0; a < NA; a++) begin
      if (acc_mask[a]) src_pos[a] = src_pos[a] + 1;
      if (src_pos[a] != stall_at[a]) stall_seen[a] = 0;
      stalled = (src_pos[a] == stall_at[a]) && (stall_seen[a] < stall_len[a]) && (src_pos[a] < src_cnt[a]);
      if (stalled) stall_seen[a] = stall_seen[a] + 1;
      in_tvalid[a]         = (src_pos[a] < src_cnt[a]) && !stalled;
      in_tdata[64*a +: 64] = src_data[a][src_pos[a] % 32];
      in_tlast[a]          = src_last[a][src_pos[a] % 32];
      in_tdest[5*a +: 5]   = src_dest[a];
    end
    outStream_tready = (ready_mode == 0) ? 1'b1 :
                       (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    acc_mask = in_tvalid & in_tready;
    cur_beat = {outStream_tdata, outStream_tlast, outStream_tdest, outStream_tid};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      checkOutput("ready_onehot0", 80'($countones(in_tready) <= 1), 80'd1);
      if (prev_hold) checkOutput("hold_stable", {5'd0, outStream_tvalid, cur_beat}, {5'd0, 1'b1, prev_beat});
      if (outStream_tvalid && outStream_tready) begin
        checkOutput("sb_nonempty", 80'(sb_q.size() != 0), 80'd1);
        if (sb_q.size() != 0) checkOutput("out_beat", 80'(cur_beat), 80'(sb_q.pop_front()));
      end
      prev_hold = outStream_tvalid && !outStream_tready;
      prev_beat = cur_beat;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    in_tvalid = '0;
    in_tdata = '0;
    in_tlast = '0;
    in_tdest = '0;
    outStream_tready = 1'b1;
    applyReset();
    checkOutput("rst_tvalid", 80'(outStream_tvalid), 80'd0);
    checkOutput("rst_tready", 80'(in_tready), 80'd0);
    checkOutput("rst_wd", 80'(wd_error), 80'd0);

    $display("[TB] test 1: acc3 3-beat packet latency");
    loadPacket(3, 3, 64'hA, 5'd1);
    @(posedge clk); #1;
    checkOutput("t1_arb_cycle", 80'(outStream_tvalid), 80'd0);
    @(posedge clk); #1;
    checkOutput("t1_beat_a", {15'd0, outStream_tvalid, outStream_tdata}, {15'd0, 1'b1, 64'hA});
    checkOutput("t1_tid", 80'(outStream_tid), 80'd3);
    @(posedge clk); #1;
    checkOutput("t1_beat_b", {15'd0, outStream_tvalid, outStream_tdata}, {15'd0, 1'b1, 64'hB});
    @(posedge clk); #1;
    checkOutput("t1_beat_c", {14'd0, outStream_tvalid, outStream_tlast, outStream_tdata}, {14'd0, 1'b1, 1'b1, 64'hC});
    waitDrain("t1_drain", 50);

    $display("[TB] test 2: round robin 0,1,5 then pointer wrap");
    applyReset();
    loadPacket(0, 2, 64'h100, 5'd2);
    loadPacket(1, 2, 64'h200, 5'd3);
    loadPacket(5, 2, 64'h500, 5'd4);
    waitDrain("t2_drain", 100);
    loadPacket(0, 2, 64'h0A0, 5'd5);
    loadPacket(5, 2, 64'h5A0, 5'd6);
    waitDrain("t2b_drain", 100);

    $display("[TB] test 3: acc15 then wrap to acc0 before acc14");
    loadPacket(15, 4, 64'hF00, 5'd7);
    repeat (3) @(posedge clk);
    #1;
    loadPacket(0, 2, 64'hA00, 5'd8);
    loadPacket(14, 2, 64'hE00, 5'd9);
    waitDrain("t3_drain", 100);

    $display("[TB] test 4: 8-beat packet with random backpressure");
    ready_mode = 1;
    loadPacket(2, 8, 64'h2000, 5'd10);
    waitDrain("t4_drain", 400);
    ready_mode = 0;
    checkOutput("t4_wd_clear", 80'(wd_error), 80'd0);

    $display("[TB] test 5: acc2 stalls mid-packet, acc6 waits");
    stall_at[2] = src_cnt[2] + 1;
    stall_len[2] = 20;
    loadPacket(2, 3, 64'h3000, 5'd11);
    repeat (3) @(posedge clk);
    #1;
    loadPacket(6, 2, 64'h6000, 5'd12);
    rdy6_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (in_tready[6]) rdy6_seen = 1'b1;
    end
    checkOutput("t5_no_preempt", 80'(rdy6_seen), 80'd0);
    waitDrain("t5_drain", 200);
    checkOutput("t5_wd", 80'(wd_error), 80'(WD_EXP));

    $display("[TB] test 6: reset with two beats buffered");
    ready_mode = 2;
    loadPacket(0, 4, 64'h7000, 5'd13);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t6_full_ready", 80'(in_tready), 80'd0);
    checkOutput("t6_head", {15'd0, outStream_tvalid, outStream_tdata}, {15'd0, 1'b1, 64'h7000});
    src_cnt[0] = src_pos[0];
    checkOutput("t6_two_taken", 80'(src_pos[0] % 32), 80'(src_cnt[0] % 32));
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    checkOutput("t6_rst_tvalid", 80'(outStream_tvalid), 80'd0);
    checkOutput("t6_rst_tready", 80'(in_tready), 80'd0);
    checkOutput("t6_rst_wd", 80'(wd_error), 80'd0);
    rst = 1'b0;
    ready_mode = 0;
    loadPacket(0, 2, 64'h0700, 5'd14);
    loadPacket(7, 2, 64'h7700, 5'd15);
    waitDrain("t6_drain", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
